// File: rtl/bin_hist_ctrl_pkg.sv
// Shared definitions for the 4-bin histogram controller.
//   state_e        : controller state encoding (IDLE / ACCUM / REPORT)
//   NUM_BINS       : number of histogram bins
//   BIN_TH1..3     : lower bounds of bins 2, 3 and 4 on the 4-bit sample scale
//   idx_to_bin()   : 0-based bin index -> 1-based bin number driven on out_bin
package bin_hist_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int NUM_BINS  = 4;
  localparam int BIN_W     = 3;
  localparam int BIN_IDX_W = 2;

  localparam logic [3:0] BIN_TH1 = 4'd4;
  localparam logic [3:0] BIN_TH2 = 4'd8;
  localparam logic [3:0] BIN_TH3 = 4'd12;

  function automatic logic [BIN_W-1:0] idx_to_bin(input logic [BIN_IDX_W-1:0] idx);
    return {1'b0, idx} + 3'd1;
  endfunction

endpackage

// File: rtl/bin_hist_ctrl_bin_classify.sv
// Combinational sample-to-bin mapper.
//   data : 4-bit unsigned sample
//   bin  : 1-based bin number (1..4)
module bin_classify
  import bin_hist_ctrl_pkg::*;
(
  input  logic [3:0]       data,
  output logic [BIN_W-1:0] bin
);

  always_comb begin
    bin = 3'd4;
    if (data < BIN_TH1)      bin = 3'd1;
    else if (data < BIN_TH2) bin = 3'd2;
    else if (data < BIN_TH3) bin = 3'd3;
  end

endmodule

// File: rtl/bin_hist_ctrl.sv
// Frame-based 4-bin histogram controller.
// Accumulates FRAME_LEN samples into four saturating bin counters, then
// reports the counts as four handshaked beats (bin 1..4) and pulses done.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : frame start (IDLE only), synchronous abort
//   in_valid/in_ready   : sample handshake, in_data is the 4-bit sample
//   out_valid/out_ready : result handshake, out_bin/out_count the beat
//   busy, done          : not-IDLE flag, one-cycle end-of-report pulse
module bin_hist_ctrl
  import bin_hist_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       out_bin,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0]       LAST_SAMP = 8'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e                             state_q, state_d;
  logic [NUM_BINS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]                         samp_q, samp_d;
  logic [BIN_IDX_W-1:0]               rpt_q, rpt_d;
  logic                               done_q, done_d;

  logic [BIN_W-1:0]     samp_bin;
  logic [BIN_IDX_W-1:0] samp_idx;

  bin_classify u_classify (
    .data (in_data),
    .bin  (samp_bin)
  );

  assign samp_idx = BIN_IDX_W'(samp_bin - 3'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;

    if (abort) begin
      // Abort wins over start and both handshakes; counters are left as-is
      // and are cleared by the next start anyway.
      state_d = ST_IDLE;
      rpt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            samp_d  = '0;
            rpt_d   = '0;
          end
        end

        ST_ACCUM: begin
          if (in_valid) begin
            if (cnt_q[samp_idx] != CNT_MAX)
              cnt_d[samp_idx] = cnt_q[samp_idx] + CNT_W'(1);
            samp_d = samp_q + 8'd1;
            if (samp_q == LAST_SAMP) begin
              state_d = ST_REPORT;
              rpt_d   = '0;
            end
          end
        end

        ST_REPORT: begin
          if (out_ready) begin
            if (rpt_q == BIN_IDX_W'(NUM_BINS - 1)) begin
              state_d = ST_IDLE;
              rpt_d   = '0;
              done_d  = 1'b1;
            end else begin
              rpt_d = rpt_q + BIN_IDX_W'(1);
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      samp_q  <= '0;
      rpt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      rpt_q   <= rpt_d;
      done_q  <= done_d;
    end
  end

  // rpt_q rests at 0 outside REPORT, so out_bin idles at 1 and out_count
  // shows the retained bin-1 count.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_REPORT);
  assign out_bin   = idx_to_bin(rpt_q);
  assign out_count = cnt_q[rpt_q];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_bin_hist_ctrl.sv
// Directed bench for bin_hist_ctrl. Three instances cover FRAME_LEN=4,
// FRAME_LEN=6 and a 2-bit-counter saturation build; each has its own start.
module tb_bin_hist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;
  logic [2:0] start_v = 3'b000;

  logic [2:0]      irdy, ovld, busy, done;
  logic [2:0][2:0] obin;
  logic [2:0][7:0] ocnt;
  logic [7:0]      oc0, oc1;
  logic [1:0]      oc_sat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin_hist_ctrl #(.FRAME_LEN(4), .CNT_W(8)) u_f4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(irdy[0]),
    .out_ready(out_ready), .out_valid(ovld[0]), .out_bin(obin[0]),
    .out_count(oc0), .busy(busy[0]), .done(done[0]));

  bin_hist_ctrl #(.FRAME_LEN(6), .CNT_W(8)) u_f6 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(irdy[1]),
    .out_ready(out_ready), .out_valid(ovld[1]), .out_bin(obin[1]),
    .out_count(oc1), .busy(busy[1]), .done(done[1]));

  bin_hist_ctrl #(.FRAME_LEN(6), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(irdy[2]),
    .out_ready(out_ready), .out_valid(ovld[2]), .out_bin(obin[2]),
    .out_count(oc_sat), .busy(busy[2]), .done(done[2]));

  assign ocnt[0] = oc0;
  assign ocnt[1] = oc1;
  assign ocnt[2] = {6'b0, oc_sat};

  // Stimulus only: start pulse then n back-to-back samples; returns #1 after
  // the edge that accepted the last sample.
  task automatic do_frame(input int sel, input int n, input logic [3:0] s [8]);
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (busy[d] !== 1'b0 || irdy[d] !== 1'b0 || ovld[d] !== 1'b0 || done[d] !== 1'b0 ||
          obin[d] !== 3'd1 || ocnt[d] !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_dut%0d: busy=%b in_ready=%b out_valid=%b done=%b bin=%0d count=%0d, expected 0 0 0 0 1 0",
                 d, busy[d], irdy[d], ovld[d], done[d], obin[d], ocnt[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [3:0] s [8] = '{4'd0, 4'd5, 4'd9, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
    out_ready = 1'b1;
    do_frame(0, 4, s);
    for (int b = 1; b <= 4; b++) begin
      vectors++;
      if (ovld[0] !== 1'b1 || obin[0] !== 3'(b) || ocnt[0] !== 8'd1) begin
        miscompares++;
        $display("FAIL basic_beat%0d: valid=%b bin=%0d count=%0d, expected valid=1 bin=%0d count=1",
                 b, ovld[0], obin[0], ocnt[0], b);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || ovld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: done=%b busy=%b out_valid=%b, expected 1 0 0", done[0], busy[0], ovld[0]);
    end
    @(posedge clk); #1;
    vectors++;
    if (done[0] !== 1'b0 || obin[0] !== 3'd1 || ocnt[0] !== 8'd1) begin
      miscompares++;
      $display("FAIL basic_idle_retain: done=%b bin=%0d count=%0d, expected done=0 bin=1 count=1",
               done[0], obin[0], ocnt[0]);
    end
  endtask

  task automatic test_boundaries;
    logic [3:0] s [8] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd11, 4'd12, 4'd0, 4'd0};
    int exp_c [4] = '{1, 2, 2, 1};
    out_ready = 1'b1;
    do_frame(1, 6, s);
    for (int b = 1; b <= 4; b++) begin
      vectors++;
      if (ovld[1] !== 1'b1 || obin[1] !== 3'(b) || ocnt[1] !== 8'(exp_c[b-1])) begin
        miscompares++;
        $display("FAIL boundary_bin%0d: valid=%b bin=%0d count=%0d, expected valid=1 bin=%0d count=%0d",
                 b, ovld[1], obin[1], ocnt[1], b, exp_c[b-1]);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_done: done=%b busy=%b, expected 1 0", done[1], busy[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [3:0] s [8] = '{4'd1, 4'd6, 4'd6, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0};
    out_ready = 1'b1;
    do_frame(0, 4, s);
    vectors++;
    if (obin[0] !== 3'd1 || ocnt[0] !== 8'd1) begin
      miscompares++;
      $display("FAIL bp_bin1: bin=%0d count=%0d, expected 1 1", obin[0], ocnt[0]);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (ovld[0] !== 1'b1 || obin[0] !== 3'd2 || ocnt[0] !== 8'd2) begin
        miscompares++;
        $display("FAIL bp_hold_cyc%0d: valid=%b bin=%0d count=%0d, expected 1 2 2",
                 c, ovld[0], obin[0], ocnt[0]);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (obin[0] !== 3'd2 || ocnt[0] !== 8'd2) begin
      miscompares++;
      $display("FAIL bp_hold_end: bin=%0d count=%0d, expected 2 2", obin[0], ocnt[0]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (obin[0] !== 3'd3 || ocnt[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL bp_bin3: bin=%0d count=%0d, expected 3 0", obin[0], ocnt[0]);
    end
    @(posedge clk); #1;
    vectors++;
    if (obin[0] !== 3'd4 || ocnt[0] !== 8'd1) begin
      miscompares++;
      $display("FAIL bp_bin4: bin=%0d count=%0d, expected 4 1", obin[0], ocnt[0]);
    end
    @(posedge clk); #1;
    vectors++;
    if (done[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_done: done=%b, expected 1", done[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate;
    logic [3:0] s [8] = '{default: 4'd0};
    int exp_c [4] = '{3, 0, 0, 0};
    out_ready = 1'b1;
    do_frame(2, 6, s);
    for (int b = 1; b <= 4; b++) begin
      vectors++;
      if (ovld[2] !== 1'b1 || obin[2] !== 3'(b) || ocnt[2] !== 8'(exp_c[b-1])) begin
        miscompares++;
        $display("FAIL sat_bin%0d: valid=%b bin=%0d count=%0d, expected valid=1 bin=%0d count=%0d",
                 b, ovld[2], obin[2], ocnt[2], b, exp_c[b-1]);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // start coinciding with done restarts cleanly; start during ACCUM is ignored.
  task automatic test_start_done;
    logic [3:0] s [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    out_ready = 1'b1;
    do_frame(0, 4, s);
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (done[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sd_done: done=%b, expected 1", done[0]);
    end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1 || irdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sd_restart: done=%b busy=%b in_ready=%b, expected 0 1 1", done[0], busy[0], irdy[0]);
    end
    // start still high in ACCUM with four samples: must finish normally.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd14;
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (ovld[0] !== 1'b1 || obin[0] !== 3'd1 || ocnt[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL sd_ignore_start: valid=%b bin=%0d count=%0d, expected 1 1 0", ovld[0], obin[0], ocnt[0]);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_abort;
    logic [3:0] s [8] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    out_ready = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    vectors++;
    if (irdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_accum_ready: in_ready=%b, expected 1", irdy[0]);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'd3;
      @(posedge clk); #1;
    end
    abort = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start_v[0] = 1'b0; in_valid = 1'b0;
    vectors++;
    if (busy[0] !== 1'b0 || irdy[0] !== 1'b0 || ovld[0] !== 1'b0 || done[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b in_ready=%b out_valid=%b done=%b, expected 0 0 0 0",
               busy[0], irdy[0], ovld[0], done[0]);
    end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_done: done=%b busy=%b, expected 0 0", done[0], busy[0]);
      end
    end
    do_frame(0, 4, s);
    vectors++;
    if (obin[0] !== 3'd1 || ocnt[0] !== 8'd4) begin
      miscompares++;
      $display("FAIL abort_clean_bin1: bin=%0d count=%0d, expected 1 4", obin[0], ocnt[0]);
    end
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (done[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_clean_done: done=%b, expected 1", done[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [3:0] s [8] = '{4'd8, 4'd8, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    int exp_c [4] = '{1, 0, 2, 1};
    out_ready = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'd12;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy[0] !== 1'b0 || irdy[0] !== 1'b0 || ovld[0] !== 1'b0 || done[0] !== 1'b0 ||
        obin[0] !== 3'd1 || ocnt[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: busy=%b in_ready=%b out_valid=%b done=%b bin=%0d count=%0d, expected 0 0 0 0 1 0",
               busy[0], irdy[0], ovld[0], done[0], obin[0], ocnt[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_no_done: done=%b busy=%b, expected 0 0", done[0], busy[0]);
      end
    end
    do_frame(0, 4, s);
    for (int b = 1; b <= 4; b++) begin
      vectors++;
      if (ovld[0] !== 1'b1 || obin[0] !== 3'(b) || ocnt[0] !== 8'(exp_c[b-1])) begin
        miscompares++;
        $display("FAIL rstmid_bin%0d: valid=%b bin=%0d count=%0d, expected valid=1 bin=%0d count=%0d",
                 b, ovld[0], obin[0], ocnt[0], b, exp_c[b-1]);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_saturate();
    test_start_done();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
